// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - program load, run control and ALU select bundle for alu_sequencer
interface alu_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic [1:0]    sel_op;
    logic [1:0]    sel_Rk;
    logic [1:0]    sel_Ri;
    logic [1:0]    sel_Rj;
    logic          alu_we;
    logic          busy;
    logic          done;
    logic [AW-1:0] pc;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start,
        input  sel_op, sel_Rk, sel_Ri, sel_Rj, alu_we, busy, done, pc
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start,
        output sel_op, sel_Rk, sel_Ri, sel_Rj, alu_we, busy, done, pc
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetches 8-bit instructions from a small program memory and issues them to an ALU
module alu_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    instr_q;
    logic [AW-1:0] pc_q, pc_nxt;
    logic [AW:0]   len_q, len_nxt, len_in;
    logic          last;

    assign len_in = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;
    assign last   = ({1'b0, pc_q} == (len_q - 1'b1));

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        len_nxt   = len_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    len_nxt = len_in;
                    if (len_in != '0) begin
                        state_nxt = S_FETCH;
                        pc_nxt    = '0;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (last) begin
                    state_nxt = S_DONE;
                end else begin
                    pc_nxt    = pc_q + 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // instr_q only loads at the end of FETCH, so the selects it drives change only on FETCH->ISSUE
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            instr_q <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            len_q <= len_nxt;
            if (state == S_FETCH) begin
                instr_q <= mem[pc_q];
            end
        end
    end

    // Program memory is not cleared by reset; writes are only honoured while idle
    always_ff @(posedge clk) begin
        if (!reset && bus.prog_we && (state == S_IDLE)) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.sel_op = instr_q[7:6];
    assign bus.sel_Rk = instr_q[5:4];
    assign bus.sel_Ri = instr_q[3:2];
    assign bus.sel_Rj = instr_q[1:0];
    assign bus.alu_we = (state == S_ISSUE);
    assign bus.busy   = (state == S_FETCH) || (state == S_ISSUE);
    assign bus.done   = (state == S_DONE);
    assign bus.pc     = pc_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;
    typedef struct packed {
        logic        is_done;
        logic [1:0]  op;
        logic [1:0]  rk;
        logic [1:0]  ri;
        logic [1:0]  rj;
        logic [3:0]  pc;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    logic [7:0] tm [16];
    logic [1:0] m_op, m_rk, m_ri, m_rj;
    logic [3:0] m_pc;
    int   we_count = 0;
    int   busy_cnt = 0;
    logic [3:0] pc_max = '0;

    alu_sequencer_if #(.AW(4)) bus ();

    alu_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        tm[a]         = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    // Expected issue/done events for a run whose start is accepted at edge base+1
    task automatic push_run(input int base, input int len, input int stop_after);
        int   l;
        ev_t  e;
        logic [7:0] d;
        l = (len > 16) ? 16 : len;
        for (int k = 0; k < l; k++) begin
            if (stop_after >= 0 && k >= stop_after) break;
            d    = tm[k];
            m_op = d[7:6];
            m_rk = d[5:4];
            m_ri = d[3:2];
            m_rj = d[1:0];
            m_pc = 4'(k);
            e = {1'b0, m_op, m_rk, m_ri, m_rj, m_pc, 32'(base + 2 + 2*k)};
            exp_q.push_back(e);
        end
        if (stop_after < 0) begin
            e = {1'b1, m_op, m_rk, m_ri, m_rj, m_pc, 32'(base + 1 + 2*l)};
            exp_q.push_back(e);
        end
    endtask

    task automatic start_run(input int len);
        bus.prog_len = 5'(len);
        bus.start    = 1'b1;
        push_run(cyc, len, -1);
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic mon_event(input logic d);
        ev_t a;
        ev_t e;
        a = {d, bus.sel_op, bus.sel_Rk, bus.sel_Ri, bus.sel_Rj, bus.pc, 32'(cyc)};
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got %h expected none", a);
        end else begin
            e = exp_q.pop_front();
            chk(d ? "done_event" : "issue_event", 64'(a), 64'(e));
        end
    endtask

    initial begin
        int base;
        reset         = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        {m_op, m_rk, m_ri, m_rj, m_pc} = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus.busy === 1'b1) busy_cnt++;
                if (bus.alu_we === 1'b1) begin
                    we_count++;
                    if (bus.pc > pc_max) pc_max = bus.pc;
                    mon_event(1'b0);
                end
                if (bus.done === 1'b1) mon_event(1'b1);
            end
        join_none

        repeat (3) tick();
        chk("reset_sel", {bus.sel_op, bus.sel_Rk, bus.sel_Ri, bus.sel_Rj}, 64'd0);
        chk("reset_ctl", {bus.alu_we, bus.busy, bus.done, bus.pc}, 64'd0);
        reset = 1'b0;

        // Three-instruction program
        load(4'd0, 8'h1B);
        load(4'd1, 8'h64);
        load(4'd2, 8'hE1);
        start_run(3);
        drain("run3_drain");
        chk("run3_hold", {bus.sel_op, bus.sel_Rk, bus.sel_Ri, bus.sel_Rj, bus.pc},
            {2'd3, 2'd2, 2'd0, 2'd1, 4'd2});
        chk("run3_idle_ctl", {bus.alu_we, bus.busy, bus.done}, 64'd0);

        // Zero-length program
        busy_cnt = 0;
        we_count = 0;
        start_run(0);
        drain("len0_drain");
        chk("len0_busy", 64'(busy_cnt), 64'd0);
        chk("len0_we", 64'(we_count), 64'd0);

        // Length clamped to DEPTH
        for (int i = 0; i < 16; i++) load(4'(i), 8'(i*37 + 11));
        we_count = 0;
        pc_max   = '0;
        start_run(20);
        drain("len20_drain");
        chk("len20_we", 64'(we_count), 64'd16);
        chk("len20_pcmax", 64'(pc_max), 64'd15);

        // Write during ISSUE ignored; start held through the run gives one run only
        load(4'd0, 8'h4E);
        load(4'd1, 8'hA7);
        load(4'd2, 8'h39);
        load(4'd3, 8'hD2);
        base          = cyc;
        bus.prog_len  = 5'd4;
        bus.start     = 1'b1;
        push_run(base, 4, -1);
        tick();
        tick();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'hFF;
        tick();
        bus.prog_we   = 1'b0;
        repeat (6) tick();
        bus.start     = 1'b0;
        drain("held_start_drain");
        start_run(4);
        drain("rerun_drain");

        // Reset in the second ISSUE aborts without done
        base         = cyc;
        bus.prog_len = 5'd4;
        bus.start    = 1'b1;
        push_run(base, 4, 2);
        tick();
        bus.start    = 1'b0;
        repeat (3) tick();
        reset        = 1'b1;
        tick();
        chk("abort_sel", {bus.sel_op, bus.sel_Rk, bus.sel_Ri, bus.sel_Rj}, 64'd0);
        chk("abort_ctl", {bus.alu_we, bus.busy, bus.done, bus.pc}, 64'd0);
        chk("abort_queue", 64'(exp_q.size()), 64'd0);
        reset = 1'b0;
        {m_op, m_rk, m_ri, m_rj, m_pc} = '0;
        we_count = 0;
        repeat (6) tick();
        chk("abort_quiet", 64'(we_count), 64'd0);
        start_run(4);
        drain("replay_drain");

        // Write coincident with accepted start is seen by the first fetch
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 8'h9C;
        tm[0]         = 8'h9C;
        start_run(1);
        bus.prog_we   = 1'b0;
        drain("wr_start_drain");

        // Reset beats start and prog_we in the same cycle
        reset         = 1'b1;
        bus.start     = 1'b1;
        bus.prog_len  = 5'd2;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd1;
        bus.prog_data = 8'h00;
        tick();
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.prog_we   = 1'b0;
        {m_op, m_rk, m_ri, m_rj, m_pc} = '0;
        tick();
        chk("rst_prio_ctl", {bus.alu_we, bus.busy, bus.done}, 64'd0);
        start_run(2);
        drain("rst_prio_drain");

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
